// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Owns the PC, issues pipelined
// valid/ready requests to the icache (up to MAX_OUTST in flight) and
// queues returned words as {pc, inst, trap} entries for IF/ID.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   redirect_valid_i/pc  flush everything and restart fetch at a new PC
//   req_*                icache request channel (valid/ready, address)
//   resp_*               icache response channel (in order, never stalled)
//   inst_*, trap_bus_o   FIFO head towards IF/ID (valid/ready)
//   ram_stall_valid_if_o high while the FIFO is empty
module fetch_queue #(
  parameter int              XLEN      = 64,
  parameter int              INST_LEN  = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
  parameter int              TRAP_LEN  = 16,
  parameter int              TRAP_MIS  = 0,
  parameter int              TRAP_AFLT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                req_valid_o,
  output logic [XLEN-1:0]     req_addr_o,
  input  logic                req_ready_i,
  input  logic                resp_valid_i,
  input  logic [XLEN-1:0]     resp_data_i,
  input  logic                resp_fault_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [XLEN-1:0]     inst_addr_o,
  output logic [INST_LEN-1:0] inst_data_o,
  output logic [TRAP_LEN-1:0] trap_bus_o,
  output logic                ram_stall_valid_if_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [INST_LEN-1:0] NOP = INST_LEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_LEN-1:0] inst;
    logic [TRAP_LEN-1:0] trap;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic            halt;
  logic [OW-1:0]   outst, drop;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  entry_t          fifo [DEPTH];
  logic [XLEN-1:0] tagq [MAX_OUTST];
  logic [TW-1:0]   tg_rd, tg_wr;

  function automatic logic [TW-1:0] tg_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  logic aligned, credit_ok, issue, resp_push, mis_push, push, pop;
  logic [XLEN-1:0] tag;
  entry_t resp_e, mis_e, push_e, head;

  // Every in-flight request holds a FIFO slot, so responses are never refused.
  assign credit_ok = (int'(count) + int'(outst)) < DEPTH;
  assign aligned   = (pc[1:0] == 2'b00);
  assign req_valid_o = rst & ~redirect_valid_i & ~halt & aligned &
                       (outst < OW'(MAX_OUTST)) & credit_ok;
  assign req_addr_o  = pc;
  assign issue       = req_valid_o & req_ready_i;

  assign tag = tagq[tg_rd];

  always_comb begin
    resp_e      = '0;
    resp_e.pc   = tag;
    resp_e.inst = resp_data_i[INST_LEN-1:0];
    if (XLEN >= 64 && tag[2]) resp_e.inst = INST_LEN'(resp_data_i >> 32);
    if (resp_fault_i) begin
      resp_e.inst            = NOP;
      resp_e.trap[TRAP_AFLT] = 1'b1;
    end
    mis_e               = '0;
    mis_e.pc            = pc;
    mis_e.inst          = NOP;
    mis_e.trap[TRAP_MIS] = 1'b1;
  end

  // A misaligned PC only exists right after a redirect, when every in-flight
  // response is already marked for drop, so the two push sources never collide.
  assign resp_push = resp_valid_i & (drop == '0) & ~redirect_valid_i;
  assign mis_push  = ~redirect_valid_i & ~halt & ~aligned & credit_ok;
  assign push      = resp_push | mis_push;
  assign push_e    = resp_push ? resp_e : mis_e;

  assign inst_valid_o = rst & (count != '0);
  assign pop          = inst_valid_o & inst_ready_i & ~redirect_valid_i;
  assign head         = fifo[rd_ptr];

  assign inst_addr_o          = inst_valid_o ? head.pc   : pc;
  assign inst_data_o          = inst_valid_o ? head.inst : NOP;
  assign trap_bus_o           = inst_valid_o ? head.trap : '0;
  assign ram_stall_valid_if_o = ~inst_valid_o;

  // Storage arrays carry no reset; pointers/counters define what is live.
  always_ff @(posedge clk) begin
    if (rst && issue) tagq[tg_wr] <= pc;
    if (rst && push && !redirect_valid_i) fifo[wr_ptr] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= RESET_PC;
      halt   <= 1'b0;
      outst  <= '0;
      drop   <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tg_rd  <= '0;
      tg_wr  <= '0;
    end else begin
      // Tag queue keeps running across redirects; stale tags drain in order.
      if (issue) begin
        tg_wr <= tg_inc(tg_wr);
        pc    <= pc + XLEN'(4);
      end
      if (resp_valid_i) tg_rd <= tg_inc(tg_rd);
      outst <= outst + OW'(issue) - OW'(resp_valid_i);

      if (redirect_valid_i) begin
        pc     <= redirect_pc_i;
        halt   <= 1'b0;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        // Everything still in flight after this cycle is stale, including
        // requests that an earlier redirect already marked for drop.
        drop   <= outst - OW'(resp_valid_i);
      end else begin
        if (resp_valid_i && drop != '0) drop <= drop - 1'b1;
        if (mis_push) halt <= 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i = 1'b1;
  logic        resp_valid_i = 1'b0;
  logic [63:0] resp_data_i = '0;
  logic        resp_fault_i = 1'b0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;
  logic [63:0] inst_addr_o;
  logic [31:0] inst_data_o;
  logic [15:0] trap_bus_o;
  logic        ram_stall_valid_if_o;

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_fault_i(resp_fault_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_addr_o(inst_addr_o), .inst_data_o(inst_data_o), .trap_bus_o(trap_bus_o),
    .ram_stall_valid_if_o(ram_stall_valid_if_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] a; logic [31:0] d; logic [15:0] t; } exp_t;
  typedef struct { logic [63:0] a; bit stale; } pend_t;

  exp_t  exp_q[$];
  pend_t pend[$];
  int    n_assert = 0, n_fail = 0, n_pops = 0, n_fires = 0;
  bit    resp_hold = 1'b0;
  logic [63:0] fault_addr = '1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Icache contents: the 8-byte block at 80000000 holds the two
  // hand-written instructions, every other word is its address ^ 0F0F0000.
  function automatic logic [31:0] word(input logic [63:0] a);
    if (a[63:3] == 61'h1000_0000) return a[2] ? 32'h0010_0093 : 32'h0000_0513;
    return a[31:0] ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [63:0] block(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    return {word(b + 64'd4), word(b)};
  endfunction

  // Icache model + scoreboard producer. Responds one cycle after the
  // request handshake unless held; requests in flight at a redirect are stale.
  initial forever begin
    pend_t p;
    exp_t  e;
    @(negedge clk);
    resp_valid_i = 1'b0;
    resp_fault_i = 1'b0;
    resp_data_i  = '0;
    if (!rst) begin
      pend.delete();
      exp_q.delete();
    end else begin
      if (redirect_valid_i) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_q.delete();
      end
      if (!resp_hold && pend.size() > 0) begin
        p = pend.pop_front();
        resp_valid_i = 1'b1;
        resp_data_i  = block(p.a);
        resp_fault_i = (p.a == fault_addr);
        if (!p.stale && !redirect_valid_i) begin
          e.a = p.a;
          e.d = resp_fault_i ? 32'h0000_0013 : word(p.a);
          e.t = resp_fault_i ? 16'h0002 : 16'h0000;
          exp_q.push_back(e);
        end
      end
      if (req_valid_o && req_ready_i) begin
        pend.push_back('{a: req_addr_o, stale: 1'b0});
        n_fires++;
      end
    end
  end

  // Monitor: every accepted head is compared with the scoreboard front.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst && inst_valid_o && inst_ready_i && !redirect_valid_i) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("unexpected_head", inst_addr_o, 64'hxxxx_xxxx_xxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("head_addr", inst_addr_o, e.a);
        chk("head_data", {32'h0, inst_data_o}, {32'h0, e.d});
        chk("head_trap", {48'h0, trap_bus_o}, {48'h0, e.t});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic redirect(input logic [63:0] a);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = a;
    cyc(1);
    redirect_valid_i = 1'b0;
  endtask

  task automatic wait_pops(input int target, input string nm);
    int k = 0;
    while (n_pops < target && k < 60) begin cyc(1); k++; end
    chk(nm, 64'(n_pops >= target), 64'd1);
  endtask

  task automatic quiesce();
    req_ready_i  = 1'b0;
    inst_ready_i = 1'b1;
    resp_hold    = 1'b0;
    cyc(8);
  endtask

  task automatic chk_reset_outs(input string tg);
    chk({tg, "_req_valid"},  64'(req_valid_o), 64'd0);
    chk({tg, "_inst_valid"}, 64'(inst_valid_o), 64'd0);
    chk({tg, "_inst_data"},  64'(inst_data_o), 64'h13);
    chk({tg, "_trap"},       64'(trap_bus_o), 64'd0);
    chk({tg, "_stall"},      64'(ram_stall_valid_if_o), 64'd1);
  endtask

  initial begin
    int f0, p0;
    #1;
    cyc(3);
    chk_reset_outs("reset");
    chk("reset_pc", inst_addr_o, 64'h8000_0000);

    // 1: first fetches after reset, then sustained 1 inst/cycle
    rst = 1'b1;
    wait_pops(2, "t1_first_two");
    cyc(4);
    chk("t1_stall", 64'(ram_stall_valid_if_o), 64'd0);
    p0 = n_pops;
    cyc(6);
    chk("t1_throughput", 64'(n_pops - p0), 64'd6);
    quiesce();

    // 2: credit limit with a blocked consumer
    inst_ready_i = 1'b0;
    req_ready_i  = 1'b1;
    redirect(64'h8000_2000);
    f0 = n_fires;
    cyc(10);
    chk("t2_fires_full", 64'(n_fires - f0), 64'd4);
    chk("t2_req_blocked", 64'(req_valid_o), 64'd0);
    chk("t2_head_addr", inst_addr_o, 64'h8000_2000);
    inst_ready_i = 1'b1;
    cyc(1);
    inst_ready_i = 1'b0;
    cyc(6);
    chk("t2_fires_after_pop", 64'(n_fires - f0), 64'd5);
    chk("t2_new_head", inst_addr_o, 64'h8000_2004);
    inst_ready_i = 1'b1;
    wait_pops(n_pops + 6, "t2_drain");
    quiesce();

    // 3: redirect with two requests in flight
    resp_hold   = 1'b1;
    req_ready_i = 1'b1;
    redirect(64'h8000_3000);
    f0 = n_fires;
    cyc(4);
    chk("t3_in_flight", 64'(n_fires - f0), 64'd2);
    chk("t3_outst_limit", 64'(req_valid_o), 64'd0);
    resp_hold = 1'b0;
    redirect(64'h8000_1000);
    chk("t3_flushed", 64'(inst_valid_o), 64'd0);
    wait_pops(n_pops + 2, "t3_new_stream");
    quiesce();

    // 4: misaligned redirect target
    inst_ready_i = 1'b0;
    req_ready_i  = 1'b1;
    redirect(64'h8000_0002);
    exp_q.push_back('{a: 64'h8000_0002, d: 32'h13, t: 16'h0001});
    f0 = n_fires;
    cyc(2);
    chk("t4_valid", 64'(inst_valid_o), 64'd1);
    chk("t4_trap", 64'(trap_bus_o), 64'd1);
    chk("t4_nop", 64'(inst_data_o), 64'h13);
    cyc(4);
    inst_ready_i = 1'b1;
    wait_pops(n_pops + 1, "t4_pop");
    cyc(3);
    chk("t4_halt_empty", 64'(inst_valid_o), 64'd0);
    chk("t4_empty_addr", inst_addr_o, 64'h8000_0002);
    chk("t4_no_fires", 64'(n_fires - f0), 64'd0);
    quiesce();

    // 5: access fault on one word of a stream
    fault_addr   = 64'h8000_0008;
    req_ready_i  = 1'b1;
    redirect(64'h8000_0000);
    wait_pops(n_pops + 5, "t5_stream");
    quiesce();
    fault_addr = '1;

    // 6: reset in the middle of a burst
    resp_hold    = 1'b1;
    inst_ready_i = 1'b0;
    req_ready_i  = 1'b1;
    redirect(64'h8000_4000);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk_reset_outs("t6");
    chk("t6_pc", inst_addr_o, 64'h8000_0000);
    resp_hold    = 1'b0;
    inst_ready_i = 1'b1;
    rst          = 1'b1;
    wait_pops(n_pops + 2, "t6_restart");
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
